// File: rtl/fetch_stage_if.sv
// Instruction-memory port: single-outstanding request/grant/rvalid handshake.
// The fetch stage is the master; the instruction memory is the slave.
interface fetch_stage_if #(
   parameter int XLEN = 32
);
   logic            req;
   logic [XLEN-1:0] addr;
   logic            gnt;
   logic            rvalid;
   logic [XLEN-1:0] rdata;

   modport master (output req, output addr, input gnt, input rvalid, input rdata);
   modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// rv32 instruction-fetch stage: owns the PC, runs the imem handshake FSM and
// drives the IF/ID pipeline register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          XLEN     = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              redirect_i,
   input  logic [XLEN-1:0]   redirect_pc_i,
   fetch_stage_if.master     imem,
   output logic              instr_stall_o,
   output logic              if_id_valid_o,
   output logic [XLEN-1:0]   if_id_pc_o,
   output logic [XLEN-1:0]   if_id_instr_o,
   output logic              misaligned_fetch_o
);

   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DROP
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] hold_q, hold_d;
   logic            if_id_valid_q;
   logic [XLEN-1:0] if_id_pc_q;
   logic [XLEN-1:0] if_id_instr_q;
   logic            misaligned_q;

   logic            redirect_ok;
   logic            deliver;
   logic [XLEN-1:0] deliver_instr;
   logic [XLEN-1:0] pc_inc;

   // A misaligned target is dropped entirely; the FSM behaves as if no redirect came.
   assign redirect_ok = redirect_i && (redirect_pc_i[1:0] == 2'b00);
   assign pc_inc      = pc_q + 32'd4;

   // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      hold_d        = hold_q;
      deliver       = 1'b0;
      deliver_instr = hold_q;

      unique case (state_q)
         S_REQ: begin
            if (redirect_ok) begin
               pc_d    = redirect_pc_i;
               state_d = imem.gnt ? S_DROP : S_REQ;
            end else if (imem.gnt) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_ok) begin
               pc_d    = redirect_pc_i;
               state_d = imem.rvalid ? S_REQ : S_DROP;
            end else if (imem.rvalid) begin
               if (!stall_i) begin
                  deliver       = 1'b1;
                  deliver_instr = imem.rdata;
                  pc_d          = pc_inc;
                  state_d       = S_REQ;
               end else begin
                  hold_d  = imem.rdata;
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (redirect_ok) begin
               pc_d    = redirect_pc_i;
               state_d = S_REQ;
            end else if (!stall_i) begin
               deliver = 1'b1;
               pc_d    = pc_inc;
               state_d = S_REQ;
            end
         end
         S_DROP: begin
            if (redirect_ok) pc_d = redirect_pc_i;
            if (imem.rvalid) state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         hold_q       <= '0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         hold_q       <= hold_d;
         misaligned_q <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
      end
   end

   // IF/ID priority: flush, then stall, then a delivered instruction, else a bubble.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         if_id_valid_q <= 1'b0;
         if_id_pc_q    <= '0;
         if_id_instr_q <= NOP;
      end else if (flush_i) begin
         if_id_valid_q <= 1'b0;
      end else if (stall_i) begin
         if_id_valid_q <= if_id_valid_q;
      end else if (deliver) begin
         if_id_valid_q <= 1'b1;
         if_id_pc_q    <= pc_q;
         if_id_instr_q <= deliver_instr;
      end else begin
         if_id_valid_q <= 1'b0;
      end
   end

   assign imem.req           = (state_q == S_REQ);
   assign imem.addr          = pc_q;
   assign instr_stall_o      = (state_q == S_WAIT) || (state_q == S_DROP);
   assign if_id_valid_o      = if_id_valid_q;
   assign if_id_pc_o         = if_id_pc_q;
   assign if_id_instr_o      = if_id_instr_q;
   assign misaligned_fetch_o = misaligned_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays the instruction memory
// cycle by cycle and checks outputs against hand-computed values.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        instr_stall;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        misaligned;

   int compared = 0;
   int mismatched = 0;

   fetch_stage_if #(.XLEN(32)) imem ();

   fetch_stage #(.RESET_PC(32'h0000_0100), .XLEN(32)) dut (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .stall_i            (stall),
      .flush_i            (flush),
      .redirect_i         (redirect),
      .redirect_pc_i      (redirect_pc),
      .imem               (imem.master),
      .instr_stall_o      (instr_stall),
      .if_id_valid_o      (if_id_valid),
      .if_id_pc_o         (if_id_pc),
      .if_id_instr_o      (if_id_instr),
      .misaligned_fetch_o (misaligned)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mem(input logic gnt, input logic rvalid, input logic [31:0] rdata);
      imem.gnt    = gnt;
      imem.rvalid = rvalid;
      imem.rdata  = rdata;
   endtask

   task automatic check_if_id(input string tag, input logic v, input logic [31:0] pc,
                              input logic [31:0] instr);
      check({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, v});
      check({tag, "_pc"}, if_id_pc, pc);
      check({tag, "_instr"}, if_id_instr, instr);
   endtask

   initial begin
      mem(1'b0, 1'b0, 32'h0);

      // Reset values
      #2 rst_n = 1'b0;
      #1;
      check("rst_req", {31'd0, imem.req}, 32'd1);
      check("rst_addr", imem.addr, 32'h100);
      check("rst_istall", {31'd0, instr_stall}, 32'd0);
      check("rst_mis", {31'd0, misaligned}, 32'd0);
      check_if_id("rst", 1'b0, 32'h0, 32'h0000_0013);
      #10 rst_n = 1'b1;

      // Sequential fetch, 1-cycle memory
      tick();
      mem(1'b1, 1'b0, 32'h0);
      tick();
      check("f0_req", {31'd0, imem.req}, 32'd0);
      check("f0_istall", {31'd0, instr_stall}, 32'd1);
      mem(1'b0, 1'b1, 32'h00A0_0093);
      tick();
      check_if_id("f0", 1'b1, 32'h100, 32'h00A0_0093);
      check("f1_addr", imem.addr, 32'h104);
      check("f1_req", {31'd0, imem.req}, 32'd1);
      mem(1'b1, 1'b0, 32'h0);
      tick();
      check("bubble_valid", {31'd0, if_id_valid}, 32'd0);

      // rvalid for 0x104 arrives under a 3-cycle stall
      stall = 1'b1;
      mem(1'b0, 1'b1, 32'h0010_8113);
      tick();
      check_if_id("stall1", 1'b0, 32'h100, 32'h00A0_0093);
      check("hold_req", {31'd0, imem.req}, 32'd0);
      check("hold_istall", {31'd0, instr_stall}, 32'd0);
      mem(1'b0, 1'b0, 32'h0);
      tick();
      tick();
      check_if_id("stall3", 1'b0, 32'h100, 32'h00A0_0093);
      check("hold_req3", {31'd0, imem.req}, 32'd0);
      stall = 1'b0;
      tick();
      check_if_id("unstall", 1'b1, 32'h104, 32'h0010_8113);
      check("unstall_addr", imem.addr, 32'h108);
      check("unstall_req", {31'd0, imem.req}, 32'd1);

      // Redirect in WAIT, late response dropped
      mem(1'b1, 1'b0, 32'h0);
      tick();
      mem(1'b0, 1'b0, 32'h0);
      redirect = 1'b1;
      redirect_pc = 32'h200;
      tick();
      redirect = 1'b0;
      check("drop_addr", imem.addr, 32'h200);
      check("drop_istall", {31'd0, instr_stall}, 32'd1);
      check("drop_req", {31'd0, imem.req}, 32'd0);
      tick();
      check("drop_wait_req", {31'd0, imem.req}, 32'd0);
      mem(1'b0, 1'b1, 32'hDEAD_BEEF);
      tick();
      mem(1'b0, 1'b0, 32'h0);
      check("drop_done_req", {31'd0, imem.req}, 32'd1);
      check("drop_done_addr", imem.addr, 32'h200);
      check("drop_valid", {31'd0, if_id_valid}, 32'd0);
      check("drop_instr", if_id_instr, 32'h0010_8113);

      // Misaligned redirect is ignored, one-cycle flag
      mem(1'b1, 1'b0, 32'h0);
      tick();
      mem(1'b0, 1'b1, 32'h0000_0113);
      redirect = 1'b1;
      redirect_pc = 32'h202;
      tick();
      redirect = 1'b0;
      mem(1'b0, 1'b0, 32'h0);
      check("mis_pulse", {31'd0, misaligned}, 32'd1);
      check_if_id("mis", 1'b1, 32'h200, 32'h0000_0113);
      check("mis_addr", imem.addr, 32'h204);
      tick();
      check("mis_clear", {31'd0, misaligned}, 32'd0);
      check("mis_addr2", imem.addr, 32'h204);

      // Flush and stall together: flush wins
      mem(1'b1, 1'b0, 32'h0);
      tick();
      mem(1'b0, 1'b1, 32'h0020_8193);
      tick();
      mem(1'b0, 1'b0, 32'h0);
      check_if_id("pre_flush", 1'b1, 32'h204, 32'h0020_8193);
      flush = 1'b1;
      stall = 1'b1;
      tick();
      flush = 1'b0;
      stall = 1'b0;
      check("flush_valid", {31'd0, if_id_valid}, 32'd0);

      // Redirect in REQ without gnt, then PC wraps past 0xFFFF_FFFC
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      check("wrap_req", {31'd0, imem.req}, 32'd1);
      check("wrap_addr", imem.addr, 32'hFFFF_FFFC);
      mem(1'b1, 1'b0, 32'h0);
      tick();
      mem(1'b0, 1'b1, 32'h0000_0013);
      tick();
      check_if_id("wrap", 1'b1, 32'hFFFF_FFFC, 32'h0000_0013);
      check("wrap_next", imem.addr, 32'h0);

      // Asynchronous reset while in WAIT
      mem(1'b1, 1'b0, 32'h0);
      tick();
      mem(1'b0, 1'b0, 32'h0);
      check("pre_rst_istall", {31'd0, instr_stall}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_req", {31'd0, imem.req}, 32'd1);
      check("arst_addr", imem.addr, 32'h100);
      check("arst_istall", {31'd0, instr_stall}, 32'd0);
      check_if_id("arst", 1'b0, 32'h0, 32'h0000_0013);
      #2 rst_n = 1'b1;
      tick();
      check("post_rst_addr", imem.addr, 32'h100);
      check("post_rst_req", {31'd0, imem.req}, 32'd1);
      mem(1'b1, 1'b0, 32'h0);
      tick();
      mem(1'b0, 1'b1, 32'h1234_5678);
      tick();
      mem(1'b0, 1'b0, 32'h0);
      check_if_id("post_rst", 1'b1, 32'h100, 32'h1234_5678);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the rv32 core.
- Owns the PC and drives a single-outstanding request/grant/rvalid instruction-memory port.
- Honours if-stage stall/flush and branch/jump redirects from the pipeline controller and EX stage.
- Reports fetch latency back to the controller via instr_stall_o.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
XLEN, 32, data and address width; only 32 is supported.

Ports:
clk_i  input  1  core clock
rst_ni  input  1  asynchronous active-low reset
stall_i  input  1  hold the IF/ID register (if_stage_stall)
flush_i  input  1  invalidate the IF/ID register (if_stage_flush)
redirect_i  input  1  change PC to redirect_pc_i (branch taken or jump)
redirect_pc_i  input  XLEN  redirect target
imem_req_o  output  1  fetch request valid
imem_addr_o  output  XLEN  fetch address, always the current PC
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  response data valid
imem_rdata_i  input  XLEN  fetched instruction
instr_stall_o  output  1  fetch is waiting on memory
if_id_valid_o  output  1  IF/ID holds a valid instruction
if_id_pc_o  output  XLEN  PC of the IF/ID instruction
if_id_instr_o  output  XLEN  IF/ID instruction
misaligned_fetch_o  output  1  one-cycle pulse: redirect target not word-aligned

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous and active-low.
- Reset values:
  - state=REQ, pc=RESET_PC.
  - if_id_valid_o=0, if_id_pc_o=0, if_id_instr_o=32'h0000_0013 (NOP).
  - misaligned_fetch_o=0, hold buffer empty.
- imem_req_o=1 only in REQ. imem_addr_o=pc in all states.
- instr_stall_o=1 in WAIT or DROP; 0 otherwise.
- The memory holds at most one outstanding request. rvalid arrives at least 1 cycle after gnt.
- State machine. Redirect always has priority over all other transitions in every state.
  - REQ:
    - redirect_i with gnt: pc<=target, go DROP.
    - redirect_i without gnt: pc<=target, stay REQ.
    - gnt without redirect: go WAIT.
    - otherwise: stay REQ.
  - WAIT:
    - redirect_i: pc<=target. If rvalid is also high, discard the response and go REQ; else go DROP.
    - rvalid with stall_i=0: load IF/ID (valid=1, pc, rdata), pc<=pc+4, go REQ.
    - rvalid with stall_i=1: capture rdata into the hold buffer, go HOLD.
  - HOLD:
    - redirect_i: discard the buffer, pc<=target, go REQ.
    - stall_i=0: load IF/ID from the buffer, pc<=pc+4, go REQ.
  - DROP: on rvalid, discard the response and go REQ. A redirect in DROP updates pc and stays DROP.
- IF/ID register priority, highest first:
  - flush_i: valid<=0.
  - stall_i: hold all fields.
  - new instruction delivered: load it.
  - otherwise: valid<=0 (bubble). pc and instr are don't-care when valid=0.
- Misaligned redirect (redirect_pc_i[1:0]!=0):
  - The redirect is ignored and the FSM proceeds as if redirect_i=0.
  - misaligned_fetch_o is registered and asserts for exactly one cycle.
- Best-case throughput is one instruction per 2 cycles with a 1-cycle memory: REQ, then WAIT.
- PC arithmetic is modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0.
- Reset mid-fetch:
  - All state is cleared immediately.
  - The memory is reset by the same rst_ni, so no stale rvalid follows.

Test Plan:
- Reset, RESET_PC=0x100, memory with 1-cycle latency returning 0x00A00093 then 0x00108113:
  - imem_addr_o=0x100 then 0x104.
  - IF/ID shows (0x100,0x00A00093), then (0x104,0x00108113).
  - if_id_valid_o alternates 1/0.
- stall_i=1 held for 3 cycles while rvalid arrives for PC 0x104:
  - FSM enters HOLD and the IF/ID contents are unchanged.
  - The cycle after stall_i drops, IF/ID=(0x104, data) and the next request is 0x108.
- redirect_i with target 0x200 in WAIT, memory rvalid arriving 2 cycles later:
  - FSM goes to DROP and the late response is discarded.
  - The next request is 0x200; IF/ID never shows the dropped word.
- redirect_i with target 0x202:
  - misaligned_fetch_o=1 for exactly one cycle.
  - PC continues sequentially (0x108 follows 0x104).
- flush_i and stall_i together while IF/ID is valid:
  - if_id_valid_o=0 the next cycle (flush wins).
- rst_ni asserted low in WAIT:
  - Outputs return to reset values asynchronously.
  - After release, the first request is RESET_PC.
